scm_port_arbiter: RTL and testbench



---
 rtl/scm_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_scm_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scm_port_arbiter.sv
`timescale 1ns/1ps
// Front end for one 1R1W latch-based register file: independent round-robin read and
// write arbiters, a same-cycle read-after-write block, and a one-cycle read response path.
module scm_port_arbiter #(
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD-1:0]            rd_req_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]            rd_gnt_o,
    output logic [NUM_RD-1:0]            rd_rvalid_o,
    output logic [DATA_WIDTH-1:0]        rd_rdata_o,
    input  logic [NUM_WR-1:0]            wr_req_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
    input  logic [NUM_WR*NUM_BYTE-1:0]   wr_be_i,
    output logic [NUM_WR-1:0]            wr_gnt_o,
    output logic                         scm_re_o,
    output logic [ADDR_WIDTH-1:0]        scm_raddr_o,
    input  logic [DATA_WIDTH-1:0]        scm_rdata_i,
    output logic                         scm_we_o,
    output logic [ADDR_WIDTH-1:0]        scm_waddr_o,
    output logic [DATA_WIDTH-1:0]        scm_wdata_o,
    output logic [NUM_BYTE-1:0]          scm_wbe_o,
    output logic [15:0]                  stall_cnt_o
);
    localparam int RD_PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int WR_PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    logic [RD_PW-1:0]  r_rd_ptr;
    logic [WR_PW-1:0]  r_wr_ptr;
    logic [NUM_RD-1:0] r_rd_sel;
    logic [15:0]       r_stall_cnt;

    logic [NUM_WR-1:0] w_wr_req;
    logic [NUM_WR-1:0] w_wr_gnt;
    logic [WR_PW-1:0]  w_wr_idx;
    logic              w_wr_any;
    logic [NUM_RD-1:0] w_rd_hazard;
    logic [NUM_RD-1:0] w_rd_elig;
    logic [NUM_RD-1:0] w_rd_gnt;
    logic [RD_PW-1:0]  w_rd_idx;
    logic              w_rd_any;

    // Masking requests in reset keeps every grant low while rst is high.
    assign w_wr_req = rst ? '0 : wr_req_i;

    always_comb begin
        w_wr_any = 1'b0;
        w_wr_idx = '0;
        w_wr_gnt = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (!w_wr_any && w_wr_req[i] && (i >= int'(r_wr_ptr))) begin
                w_wr_any    = 1'b1;
                w_wr_idx    = WR_PW'(i);
                w_wr_gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_WR; i++) begin
            if (!w_wr_any && w_wr_req[i]) begin
                w_wr_any    = 1'b1;
                w_wr_idx    = WR_PW'(i);
                w_wr_gnt[i] = 1'b1;
            end
        end
    end

    always_comb begin
        scm_waddr_o = '0;
        scm_wdata_o = '0;
        scm_wbe_o   = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (w_wr_gnt[i]) begin
                scm_waddr_o = wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                scm_wdata_o = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                scm_wbe_o   = wr_be_i[i*NUM_BYTE +: NUM_BYTE];
            end
        end
    end

    assign scm_we_o = w_wr_any;
    assign wr_gnt_o = w_wr_gnt;

    // The latches are still transparent in the cycle after the write edge, so a read of
    // the word being written this cycle would sample unsettled data.
    always_comb begin
        w_rd_hazard = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_hazard[i] = rd_req_i[i] && scm_we_o &&
                             (rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == scm_waddr_o);
        end
    end

    assign w_rd_elig = rst ? '0 : (rd_req_i & ~w_rd_hazard);

    always_comb begin
        w_rd_any = 1'b0;
        w_rd_idx = '0;
        w_rd_gnt = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (!w_rd_any && w_rd_elig[i] && (i >= int'(r_rd_ptr))) begin
                w_rd_any    = 1'b1;
                w_rd_idx    = RD_PW'(i);
                w_rd_gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_RD; i++) begin
            if (!w_rd_any && w_rd_elig[i]) begin
                w_rd_any    = 1'b1;
                w_rd_idx    = RD_PW'(i);
                w_rd_gnt[i] = 1'b1;
            end
        end
    end

    always_comb begin
        scm_raddr_o = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_rd_gnt[i]) begin
                scm_raddr_o = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign scm_re_o = w_rd_any;
    assign rd_gnt_o = w_rd_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_sel    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_wr_any) begin
                r_wr_ptr <= (int'(w_wr_idx) == NUM_WR - 1) ? '0 : w_wr_idx + 1'b1;
            end
            if (w_rd_any) begin
                r_rd_ptr <= (int'(w_rd_idx) == NUM_RD - 1) ? '0 : w_rd_idx + 1'b1;
            end
            r_rd_sel <= w_rd_gnt;
            if ((|w_rd_hazard) && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign rd_rvalid_o = r_rd_sel;
    assign rd_rdata_o  = (|r_rd_sel) ? scm_rdata_i : '0;
    assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_scm_port_arbiter.sv
`timescale 1ns/1ps
// Bench for scm_port_arbiter: vector table, directed corner sequences and a randomized
// run, all checked against a port-level reference model and a behavioural register file.
module tb_scm_port_arbiter;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     rd_req;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR-1:0]     rd_gnt;
    logic [NR-1:0]     rd_rvalid;
    logic [DW-1:0]     rd_rdata;
    logic [NW-1:0]     wr_req;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic [NW*NB-1:0]  wr_be;
    logic [NW-1:0]     wr_gnt;
    logic              scm_re;
    logic [AW-1:0]     scm_raddr;
    logic [DW-1:0]     scm_rdata;
    logic              scm_we;
    logic [AW-1:0]     scm_waddr;
    logic [DW-1:0]     scm_wdata;
    logic [NB-1:0]     scm_wbe;
    logic [15:0]       stall_cnt;

    always #5 clk = ~clk;

    scm_port_arbiter #(
        .NUM_RD(NR), .NUM_WR(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
        .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
        .wr_gnt_o(wr_gnt),
        .scm_re_o(scm_re), .scm_raddr_o(scm_raddr), .scm_rdata_i(scm_rdata),
        .scm_we_o(scm_we), .scm_waddr_o(scm_waddr), .scm_wdata_o(scm_wdata),
        .scm_wbe_o(scm_wbe), .stall_cnt_o(stall_cnt)
    );

    // Register file: write committed at the grant edge, read address registered.
    logic [DW-1:0] rf_mem [32];
    logic [AW-1:0] rf_raddr_q;
    logic          mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
            rf_raddr_q <= '0;
        end else begin
            if (scm_re) rf_raddr_q <= scm_raddr;
            if (scm_we)
                for (int b = 0; b < NB; b++)
                    if (scm_wbe[b]) rf_mem[scm_waddr][8*b +: 8] <= scm_wdata[8*b +: 8];
        end
    end
    assign scm_rdata = rf_mem[rf_raddr_q];

    logic          rq_r [NR];
    logic [AW-1:0] ad_r [NR];
    logic          rq_w [NW];
    logic [AW-1:0] ad_w [NW];
    logic [DW-1:0] dt_w [NW];
    logic [NB-1:0] be_w [NW];

    int            m_wr_ptr, m_rd_ptr, m_rsel, m_stall;
    logic [DW-1:0] m_mem [32];
    logic [DW-1:0] m_pend;
    int            e_wwin, e_rwin;
    bit            e_blk_any;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]    rreq;
        logic [AW-1:0] ra0, ra1;
        logic [1:0]    wreq;
        logic [AW-1:0] wa0, wa1;
        logic [1:0]    erg, ewg;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin rq_r[i] = 1'b0; ad_r[i] = '0; end
        for (int i = 0; i < NW; i++) begin
            rq_w[i] = 1'b0; ad_w[i] = '0; dt_w[i] = '0; be_w[i] = '0;
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NR; i++) begin
            rd_req[i] = rq_r[i];
            rd_addr[i*AW +: AW] = ad_r[i];
        end
        for (int i = 0; i < NW; i++) begin
            wr_req[i] = rq_w[i];
            wr_addr[i*AW +: AW] = ad_w[i];
            wr_data[i*DW +: DW] = dt_w[i];
            wr_be[i*NB +: NB]   = be_w[i];
        end
    endtask

    // Winner = first requester scanning from the pointer with wrap; a read is
    // skipped when its word is the one being written this cycle.
    task automatic model_eval();
        e_wwin = -1;
        e_rwin = -1;
        e_blk_any = 1'b0;
        if (!rst) begin
            for (int j = 0; j < NW; j++) begin
                int p;
                p = (m_wr_ptr + j) % NW;
                if (e_wwin < 0 && rq_w[p]) e_wwin = p;
            end
            for (int j = 0; j < NR; j++) begin
                int p;
                p = (m_rd_ptr + j) % NR;
                if (rq_r[p] && e_wwin >= 0 && ad_r[p] == ad_w[e_wwin]) e_blk_any = 1'b1;
                else if (e_rwin < 0 && rq_r[p]) e_rwin = p;
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_wr_ptr = 0; m_rd_ptr = 0; m_rsel = -1; m_stall = 0;
        end else begin
            if (e_rwin >= 0) begin
                m_pend   = m_mem[ad_r[e_rwin]];
                m_rsel   = e_rwin;
                m_rd_ptr = (e_rwin + 1) % NR;
            end else begin
                m_rsel = -1;
            end
            if (e_wwin >= 0) begin
                for (int b = 0; b < NB; b++)
                    if (be_w[e_wwin][b]) m_mem[ad_w[e_wwin]][8*b +: 8] = dt_w[e_wwin][8*b +: 8];
                m_wr_ptr = (e_wwin + 1) % NW;
            end
            if (e_blk_any && m_stall < 65535) m_stall++;
        end
    endtask

    // Called shortly after a rising edge; compares on the falling edge.
    task automatic settle(input bit do_chk);
        pack();
        #4;
        model_eval();
        if (do_chk) begin
            chk("rd_gnt", 64'(rd_gnt), 64'((e_rwin >= 0) ? (1 << e_rwin) : 0));
            chk("wr_gnt", 64'(wr_gnt), 64'((e_wwin >= 0) ? (1 << e_wwin) : 0));
            chk("scm_we", 64'(scm_we), 64'(e_wwin >= 0));
            if (e_wwin >= 0) begin
                chk("scm_waddr", 64'(scm_waddr), 64'(ad_w[e_wwin]));
                chk("scm_wdata", 64'(scm_wdata), 64'(dt_w[e_wwin]));
                chk("scm_wbe",   64'(scm_wbe),   64'(be_w[e_wwin]));
            end
            chk("scm_re", 64'(scm_re), 64'(e_rwin >= 0));
            chk("scm_raddr", 64'(scm_raddr), 64'((e_rwin >= 0) ? ad_r[e_rwin] : '0));
            chk("rd_rvalid", 64'(rd_rvalid), 64'((!rst && m_rsel >= 0) ? (1 << m_rsel) : 0));
            chk("rd_rdata", 64'(rd_rdata), 64'((!rst && m_rsel >= 0) ? m_pend : '0));
            chk("stall_cnt", 64'(stall_cnt), 64'(rst ? 0 : m_stall));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        m_wr_ptr = 0; m_rd_ptr = 0; m_rsel = -1; m_stall = 0; m_pend = '0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        clear_reqs();
        pack();

        tbl[0]  = '{2'b11, 5'd1,  5'd2,  2'b11, 5'd10, 5'd11, 2'b01, 2'b01};
        tbl[1]  = '{2'b11, 5'd1,  5'd2,  2'b11, 5'd10, 5'd11, 2'b10, 2'b10};
        tbl[2]  = '{2'b11, 5'd1,  5'd2,  2'b11, 5'd10, 5'd11, 2'b01, 2'b01};
        tbl[3]  = '{2'b11, 5'd1,  5'd2,  2'b11, 5'd10, 5'd11, 2'b10, 2'b10};
        tbl[4]  = '{2'b01, 5'd1,  5'd2,  2'b10, 5'd10, 5'd11, 2'b01, 2'b10};
        tbl[5]  = '{2'b01, 5'd3,  5'd2,  2'b00, 5'd10, 5'd11, 2'b01, 2'b00};
        tbl[6]  = '{2'b01, 5'd10, 5'd12, 2'b01, 5'd10, 5'd11, 2'b00, 2'b01};
        tbl[7]  = '{2'b01, 5'd10, 5'd12, 2'b00, 5'd10, 5'd11, 2'b01, 2'b00};
        tbl[8]  = '{2'b11, 5'd7,  5'd8,  2'b01, 5'd7,  5'd11, 2'b10, 2'b01};
        tbl[9]  = '{2'b01, 5'd7,  5'd8,  2'b00, 5'd7,  5'd11, 2'b01, 2'b00};
        tbl[10] = '{2'b00, 5'd7,  5'd8,  2'b00, 5'd7,  5'd11, 2'b00, 2'b00};

        @(posedge clk);
        #1;
        mem_clr = 1'b0;

        // Reset held with every request high.
        for (int i = 0; i < NR; i++) begin rq_r[i] = 1'b1; ad_r[i] = 5'(i + 1); end
        for (int i = 0; i < NW; i++) begin
            rq_w[i] = 1'b1; ad_w[i] = 5'(i + 16); dt_w[i] = 32'h5555_0000; be_w[i] = 4'hF;
        end
        settle(1);
        chk("rst_rd_gnt", 64'(rd_gnt), 64'(0));
        chk("rst_wr_gnt", 64'(wr_gnt), 64'(0));
        advance();
        rst = 1'b0;
        clear_reqs();
        settle(1);
        advance();

        for (int r = 0; r < 11; r++) begin
            clear_reqs();
            rq_r[0] = tbl[r].rreq[0]; rq_r[1] = tbl[r].rreq[1];
            ad_r[0] = tbl[r].ra0;     ad_r[1] = tbl[r].ra1;
            rq_w[0] = tbl[r].wreq[0]; rq_w[1] = tbl[r].wreq[1];
            ad_w[0] = tbl[r].wa0;     ad_w[1] = tbl[r].wa1;
            for (int i = 0; i < NW; i++) begin
                dt_w[i] = 32'hA500_0000 | 32'(r << 8) | 32'(i);
                be_w[i] = 4'hF;
            end
            settle(1);
            chk("tbl_rd_gnt", 64'(rd_gnt), 64'(tbl[r].erg));
            chk("tbl_wr_gnt", 64'(wr_gnt), 64'(tbl[r].ewg));
            advance();
        end

        // Write then read the next cycle.
        clear_reqs();
        rq_w[0] = 1'b1; ad_w[0] = 5'd3; dt_w[0] = 32'hDEADBEEF; be_w[0] = 4'hF;
        settle(1); advance();
        clear_reqs();
        rq_r[0] = 1'b1; ad_r[0] = 5'd3;
        settle(1);
        chk("wr_rd_gnt", 64'(rd_gnt), 64'(1));
        advance();
        clear_reqs();
        settle(1);
        chk("wr_rd_rvalid", 64'(rd_rvalid), 64'(1));
        chk("wr_rd_rdata", 64'(rd_rdata), 64'(32'hDEADBEEF));
        advance();

        // Byte-enable merge, then a BE=0 write that must not change the word.
        clear_reqs();
        rq_w[0] = 1'b1; ad_w[0] = 5'd5; dt_w[0] = 32'h11223344; be_w[0] = 4'hF;
        settle(1); advance();
        dt_w[0] = 32'hAABBCCDD; be_w[0] = 4'h5;
        settle(1); advance();
        dt_w[0] = 32'hFFFFFFFF; be_w[0] = 4'h0;
        settle(1);
        chk("be0_we", 64'(scm_we), 64'(1));
        advance();
        clear_reqs();
        rq_r[1] = 1'b1; ad_r[1] = 5'd5;
        settle(1); advance();
        clear_reqs();
        settle(1);
        chk("be_rvalid", 64'(rd_rvalid), 64'(2));
        chk("be_rdata", 64'(rd_rdata), 64'(32'h11BB33DD));
        advance();

        // Reset in the middle of a pending read response.
        clear_reqs();
        rq_r[0] = 1'b1; ad_r[0] = 5'd9;
        rq_r[1] = 1'b1; ad_r[1] = 5'd4;
        settle(1); advance();
        rst = 1'b1;
        #1;
        chk("rst_kills_rvalid", 64'(rd_rvalid), 64'(0));
        settle(1); advance();
        rst = 1'b0;
        rq_w[0] = 1'b1; ad_w[0] = 5'd20; dt_w[0] = 32'h0BAD_F00D; be_w[0] = 4'hF;
        rq_w[1] = 1'b1; ad_w[1] = 5'd21; dt_w[1] = 32'h1234_5678; be_w[1] = 4'hF;
        settle(1);
        chk("post_rst_rd_gnt", 64'(rd_gnt), 64'(1));
        chk("post_rst_wr_gnt", 64'(wr_gnt), 64'(1));
        advance();
        clear_reqs();
        settle(1); advance();

        // Randomized traffic; each requester holds until granted.
        for (int c = 0; c < 3000; c++) begin
            settle(1);
            advance();
            for (int i = 0; i < NR; i++) begin
                if (rq_r[i] && e_rwin == i) rq_r[i] = 1'b0;
                if (!rq_r[i] && $urandom_range(1, 0) == 1) begin
                    rq_r[i] = 1'b1;
                    ad_r[i] = 5'($urandom_range(7, 0));
                end
            end
            for (int i = 0; i < NW; i++) begin
                if (rq_w[i] && e_wwin == i) rq_w[i] = 1'b0;
                if (!rq_w[i] && $urandom_range(1, 0) == 1) begin
                    rq_w[i] = 1'b1;
                    ad_w[i] = 5'($urandom_range(7, 0));
                    dt_w[i] = $urandom;
                    be_w[i] = 4'($urandom_range(15, 0));
                end
            end
        end

        // Hold a same-word hazard long enough to saturate the stall counter.
        clear_reqs();
        rq_r[0] = 1'b1; ad_r[0] = 5'd20;
        rq_w[0] = 1'b1; ad_w[0] = 5'd20; dt_w[0] = 32'hC0FFEE00; be_w[0] = 4'hF;
        for (int c = 0; c < 65540; c++) begin
            settle(0);
            advance();
        end
        settle(1);
        chk("stall_sat", 64'(stall_cnt), 64'(16'hFFFF));
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
